// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from a 50 MHz clock.
// Publishes the pixel coordinate to the colour stage and re-times the
// returned RGB together with hsync/vsync/blank onto the DAC pins so that
// colour and sync for one pixel leave the block on the same pixel tick.
// PIPE_DELAY must lie in 1..4.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2,
  parameter int DATA_W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] vga_r,
  input  logic [DATA_W-1:0] vga_g,
  input  logic [DATA_W-1:0] vga_b,
  output logic [9:0]        x_addr,
  output logic [9:0]        y_addr,
  output logic [DATA_W-1:0] vga_r_DAC,
  output logic [DATA_W-1:0] vga_g_DAC,
  output logic [DATA_W-1:0] vga_b_DAC,
  output logic              vga_clock,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank,
  output logic              vga_sync_dac,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Alignment word {hs, vs, vis}; idle means both syncs inactive, not visible.
  localparam logic [2:0] ALGN_IDLE = 3'b110;

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       h_vis;
  logic       v_vis;
  logic       vis;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] algn_p0;
  logic [2:0] algn_q [1:PIPE_DELAY];
  logic [2:0] last_ld;

  assign vga_sync_dac = 1'b0;

  // Divide-by-two pixel enable and the DAC clock derived from it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en    <= 1'b0;
      vga_clock <= 1'b1;
    end else begin
      pix_en    <= ~pix_en;
      vga_clock <= ~pix_en;
    end
  end

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster counters: column advances every tick, row advances on column wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Flag the tick clock that sits on the origin (next edge is a tick at (0,0)).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) frame_start <= 1'b0;
    else       frame_start <= ~pix_en && (h_cnt == '0) && (v_cnt == '0);
  end

  // ---- stage p0: coordinate and raw sync decode from the counters ----
  // Combinational decode of visibility, coordinates and raw syncs.
  always_comb begin
    h_vis   = (h_cnt < H_VIS);
    v_vis   = (v_cnt < V_VIS);
    vis     = h_vis && v_vis;
    x_addr  = vis   ? h_cnt : 10'h3FF;
    y_addr  = v_vis ? v_cnt : 10'h3FF;
    hs_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    algn_p0 = {hs_raw, vs_raw, vis};
  end

  // ---- stages 1..PIPE_DELAY: sync/blank delay line matching colour latency ----
  // Shift the alignment word one stage per tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= PIPE_DELAY; i++) algn_q[i] <= ALGN_IDLE;
    end else if (pix_en) begin
      algn_q[1] <= algn_p0;
      for (int i = 2; i <= PIPE_DELAY; i++) algn_q[i] <= algn_q[i-1];
    end
  end

  // The word entering the last stage decides whether colour is passed this tick.
  generate
    if (PIPE_DELAY == 1) begin : g_ld_direct
      assign last_ld = algn_p0;
    end else begin : g_ld_shift
      assign last_ld = algn_q[PIPE_DELAY-1];
    end
  endgenerate

  assign vga_hs    = algn_q[PIPE_DELAY][2];
  assign vga_vs    = algn_q[PIPE_DELAY][1];
  assign vga_blank = algn_q[PIPE_DELAY][0];

  // ---- DAC stage: colour captured alongside the last alignment stage ----
  // Register colour for visible pixels, force black elsewhere.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_r_DAC <= '0;
      vga_g_DAC <= '0;
      vga_b_DAC <= '0;
    end else if (pix_en) begin
      vga_r_DAC <= last_ld[0] ? vga_r : '0;
      vga_g_DAC <= last_ld[0] ? vga_g : '0;
      vga_b_DAC <= last_ld[0] ? vga_b : '0;
    end
  end

endmodule
